// File: rtl/chn_burst_merger.sv
// N-channel round-robin burst merger: per-channel sample FIFOs drained in fixed-length
// bursts, optionally headed by a channel tag word, into the USB external FIFO.
module chn_burst_merger #(
  parameter int unsigned NUM_CHN   = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FIFO_AW   = 11,
  parameter int unsigned BURST_LEN = 1024,
  parameter int unsigned HEADER_EN = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rst_all_fifo,
  input  logic [NUM_CHN*DATA_W-1:0]   chn_dataout,
  input  logic [NUM_CHN-1:0]          chn_dataout_en,
  input  logic                        out_full,
  output logic [DATA_W-1:0]           out_to_usb_ext_fifo_din,
  output logic                        out_to_usb_ext_fifo_en,
  output logic [NUM_CHN-1:0]          overflow,
  output logic                        busy,
  output logic [3:0]                  cur_chn
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CHN_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned USE_W = FIFO_AW + 1;

  localparam logic [USE_W-1:0] BURST_USED = USE_W'(BURST_LEN);
  localparam logic [USE_W-1:0] FULL_USED  = USE_W'(DEPTH);
  localparam logic [CNT_W-1:0] BURST_CNT  = CNT_W'(BURST_LEN);
  localparam logic [CHN_W-1:0] LAST_CHN   = CHN_W'(NUM_CHN - 1);

  typedef enum logic [1:0] {S_SCAN, S_HEADER, S_BURST, S_NEXT} state_t;

  state_t             state_q, state_d;
  logic [CHN_W-1:0]   chn_q, chn_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rd_en_c;
  logic               hdr_en_c;
  logic               flush;

  logic [DATA_W-1:0]  mem [NUM_CHN][DEPTH];
  logic [FIFO_AW-1:0] wr_ptr [NUM_CHN];
  logic [FIFO_AW-1:0] rd_ptr [NUM_CHN];
  logic [USE_W-1:0]   usedw [NUM_CHN];
  logic [NUM_CHN-1:0] wr_ok_c;
  logic [NUM_CHN-1:0] rd_sel_c;

  logic [DATA_W-1:0]  rd_data_q;
  logic               rd_vld_q;
  logic [DATA_W-1:0]  hdr_word;

  assign flush   = reset | rst_all_fifo;
  assign cur_chn = 4'(chn_q);

  // Per-channel write acceptance and read selection
  always_comb begin
    wr_ok_c  = '0;
    rd_sel_c = '0;
    for (int i = 0; i < NUM_CHN; i++) begin
      wr_ok_c[i]  = chn_dataout_en[i] && (usedw[i] != FULL_USED) && !flush;
      rd_sel_c[i] = rd_en_c && (chn_q == CHN_W'(i));
    end
  end

  // Sample storage and registered read port (one read per cycle, channel chn_q)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHN; i++) begin
      if (wr_ok_c[i]) mem[i][wr_ptr[i]] <= chn_dataout[i*DATA_W +: DATA_W];
    end
    if (rd_en_c) rd_data_q <= mem[chn_q][rd_ptr[chn_q]];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < NUM_CHN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        usedw[i]  <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CHN; i++) begin
        if (wr_ok_c[i])  wr_ptr[i] <= wr_ptr[i] + FIFO_AW'(1);
        if (rd_sel_c[i]) rd_ptr[i] <= rd_ptr[i] + FIFO_AW'(1);
        if (wr_ok_c[i] && !rd_sel_c[i])      usedw[i] <= usedw[i] + USE_W'(1);
        else if (!wr_ok_c[i] && rd_sel_c[i]) usedw[i] <= usedw[i] - USE_W'(1);
        if (chn_dataout_en[i] && (usedw[i] == FULL_USED)) overflow[i] <= 1'b1;
      end
    end
  end

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= S_SCAN;
      chn_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      chn_q   <= chn_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == S_HEADER) || (state_d == S_BURST);
    end
  end

  // Arbiter next state; the first read is issued alongside the header (or at selection
  // when headers are off) so the two-stage data path streams without a bubble.
  always_comb begin
    state_d  = state_q;
    chn_d    = chn_q;
    cnt_d    = cnt_q;
    rd_en_c  = 1'b0;
    hdr_en_c = 1'b0;
    case (state_q)
      S_SCAN: begin
        if (usedw[chn_q] >= BURST_USED) begin
          cnt_d = '0;
          if (HEADER_EN != 0) begin
            state_d = S_HEADER;
          end else begin
            state_d = S_BURST;
            if (!out_full) begin
              rd_en_c = 1'b1;
              cnt_d   = CNT_W'(1);
              if (BURST_CNT == CNT_W'(1)) state_d = S_NEXT;
            end
          end
        end else begin
          state_d = S_NEXT;
        end
      end
      S_HEADER: begin
        if (!out_full) begin
          hdr_en_c = 1'b1;
          rd_en_c  = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = (BURST_CNT == CNT_W'(1)) ? S_NEXT : S_BURST;
        end
      end
      S_BURST: begin
        if (!out_full) begin
          rd_en_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == BURST_CNT) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        chn_d   = (chn_q == LAST_CHN) ? '0 : chn_q + CHN_W'(1);
        state_d = S_SCAN;
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_comb begin
    hdr_word        = '0;
    hdr_word[15:0]  = {8'hA5, 4'h0, cur_chn};
  end

  // Output register and read-valid pipeline stage
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_vld_q                <= 1'b0;
      out_to_usb_ext_fifo_en  <= 1'b0;
      out_to_usb_ext_fifo_din <= '0;
    end else begin
      rd_vld_q <= rd_en_c;
      if (hdr_en_c) begin
        out_to_usb_ext_fifo_en  <= 1'b1;
        out_to_usb_ext_fifo_din <= hdr_word;
      end else if (rd_vld_q) begin
        out_to_usb_ext_fifo_en  <= 1'b1;
        out_to_usb_ext_fifo_din <= rd_data_q;
      end else begin
        out_to_usb_ext_fifo_en  <= 1'b0;
      end
    end
  end

endmodule
